// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

    // Register-number width
    localparam int REG_W  = 5;
    // Width of the memory wait-state down-counter (MEM_WAIT 0..15)
    localparam int WAIT_W = 4;

    // Operand-forward select encoding
    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_t;

    // Destination info shadowed for one pipeline stage
    typedef struct packed {
        logic [REG_W-1:0] rn;
        logic             wreg;
        logic             m2reg;
    } shadow_t;

endpackage

// File: rtl/fwd_select.sv
// Operand-forward select for one source register. First match wins:
// EX ALU result, then MEM (ALU or load data), otherwise the register file.
module fwd_select
    import pipe_hazard_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    input  logic [REG_W-1:0] ex_rn_i,
    input  logic             ex_wreg_i,
    input  logic             ex_m2reg_i,
    input  logic [REG_W-1:0] mem_rn_i,
    input  logic             mem_wreg_i,
    input  logic             mem_m2reg_i,
    output logic [1:0]       sel_o
);

    // Priority compare against the EX shadow, then the MEM shadow.
    // A load in EX is never forwarded; that case is covered by the load-use stall.
    always_comb begin
        sel_o = FWD_RF;
        if (use_i && (src_i != '0)) begin
            if (ex_wreg_i && !ex_m2reg_i && (ex_rn_i == src_i)) begin
                sel_o = FWD_EXALU;
            end else if (mem_wreg_i && (mem_rn_i == src_i)) begin
                sel_o = mem_m2reg_i ? FWD_MEMLD : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage pipeline.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | normal flow; forwarding, load-use stall and flush active
// ST_MEMWAIT | load in MEM waiting on data memory; whole pipeline frozen
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_regrt,
    input  logic [REG_W-1:0] id_rn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic [1:0]       id_pcsource,
    output logic             wpcir,
    output logic             bubble,
    output logic             flush_ifid,
    output logic             freeze,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit                HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    shadow_t           ex_q, ex_d;
    shadow_t           mem_q, mem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic uses_rt;
    logic ldu;
    logic load_enters_mem;

    // Source usage and load-use detection against the load sitting in EX.
    always_comb begin
        uses_rt = ~id_regrt | id_wmem;
        ldu     = ex_q.wreg & ex_q.m2reg & (ex_q.rn != '0) &
                  ((ex_q.rn == id_rs) | (uses_rt & (ex_q.rn == id_rt)));
    end

    // Freeze only exists when memory has wait states; it dominates every
    // other control so nothing is decided on operands that are not yet valid.
    always_comb begin
        freeze     = HAS_WAIT & (state_q == ST_MEMWAIT);
        bubble     = ldu & ~freeze;
        wpcir      = ~(ldu | freeze);
        flush_ifid = (id_pcsource != 2'b00) & ~ldu & ~freeze;
    end

    fwd_select u_fwd_rs (
        .src_i       (id_rs),
        .use_i       (1'b1),
        .ex_rn_i     (ex_q.rn),
        .ex_wreg_i   (ex_q.wreg),
        .ex_m2reg_i  (ex_q.m2reg),
        .mem_rn_i    (mem_q.rn),
        .mem_wreg_i  (mem_q.wreg),
        .mem_m2reg_i (mem_q.m2reg),
        .sel_o       (fwda)
    );

    fwd_select u_fwd_rt (
        .src_i       (id_rt),
        .use_i       (uses_rt),
        .ex_rn_i     (ex_q.rn),
        .ex_wreg_i   (ex_q.wreg),
        .ex_m2reg_i  (ex_q.m2reg),
        .mem_rn_i    (mem_q.rn),
        .mem_wreg_i  (mem_q.wreg),
        .mem_m2reg_i (mem_q.m2reg),
        .sel_o       (fwdb)
    );

    // Next shadow values: advance one stage unless frozen; a bubble enters EX as all zeros.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!freeze) begin
            mem_d = ex_q;
            if (bubble) begin
                ex_d = '0;
            end else begin
                ex_d.rn    = id_rn;
                ex_d.wreg  = id_wreg;
                ex_d.m2reg = id_m2reg;
            end
        end
    end

    assign load_enters_mem = ex_q.m2reg & ex_q.wreg & ~freeze;

    // Next-state logic: a load entering MEM arms the wait down-counter;
    // the pipeline is released on the cycle the counter reaches one.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (HAS_WAIT && load_enters_mem) begin
                    state_d = ST_MEMWAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            ST_MEMWAIT: begin
                wait_d = wait_q - WAIT_ONE;
                if (wait_q == WAIT_ONE) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Saturating count of cycles in which the front end could not advance.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((~wpcir | freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // State, shadow and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
